// File: rtl/univ_shift_reg_burst_if.sv
// Bus bundle for univ_shift_reg_burst: operation controls, burst handshake and register outputs.
// With SHREG_SNAPSHOT_EN defined the bundle also carries q_snap / snap_valid.
interface univ_shift_reg_burst_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [CNT_W-1:0] shift_cnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             state_dbg;
`ifdef SHREG_SNAPSHOT_EN
    logic [WIDTH-1:0] q_snap;
    logic             snap_valid;

    modport master (
        output en, mode, d, sin_l, sin_r, start, shift_cnt,
        input  busy, done, q, sout_l, sout_r, state_dbg, q_snap, snap_valid
    );
    modport slave (
        input  en, mode, d, sin_l, sin_r, start, shift_cnt,
        output busy, done, q, sout_l, sout_r, state_dbg, q_snap, snap_valid
    );
`else
    modport master (
        output en, mode, d, sin_l, sin_r, start, shift_cnt,
        input  busy, done, q, sout_l, sout_r, state_dbg
    );
    modport slave (
        input  en, mode, d, sin_l, sin_r, start, shift_cnt,
        output busy, done, q, sout_l, sout_r, state_dbg
    );
`endif
endinterface

// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with single-cycle ops and a counted burst mode (busy/done).
// Optional macro SHREG_SNAPSHOT_EN adds q_snap/snap_valid capturing the post-burst value.
module univ_shift_reg_burst #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                  clk,
    input logic                  reset_n,
    univ_shift_reg_burst_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       run_mode_q, run_mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             burst_go;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) || (m == M_ROR) || (m == M_ASR);
    endfunction

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] load_val,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (m)
            M_SHL:   r = {v[WIDTH-2:0], sl};
            M_SHR:   r = {sr, v[WIDTH-1:1]};
            M_LOAD:  r = load_val;
            M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   r = {v[0], v[WIDTH-1:1]};
            M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    // Handshake: in IDLE with en=1, start is accepted together with a shift-class mode;
    // busy is high for the whole burst, done is a one-cycle pulse after the last shift
    // (or after a zero-length request), and a new start may coincide with that done cycle.
    assign burst_go = bus.en && bus.start && is_shift(bus.mode) && (bus.shift_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            q_q         <= RESET_VAL;
            run_mode_q  <= M_HOLD;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            run_mode_q  <= run_mode_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (burst_go) state_d = RUN;
            RUN:     if (bus.en && remaining_q == CNT_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SHREG_SNAPSHOT_EN
    logic snap_clr;
`endif

    always_comb begin
        q_d         = q_q;
        run_mode_d  = run_mode_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
`ifdef SHREG_SNAPSHOT_EN
        snap_clr    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    if (bus.start && is_shift(bus.mode)) begin
                        // Zero-length burst: report completion without touching q.
                        if (bus.shift_cnt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            run_mode_d  = bus.mode;
                            remaining_d = bus.shift_cnt;
                        end
                    end else begin
                        q_d = apply_mode(bus.mode, q_q, bus.d, bus.sin_l, bus.sin_r);
`ifdef SHREG_SNAPSHOT_EN
                        snap_clr = (bus.mode == M_LOAD) || (bus.mode == M_CLR);
`endif
                    end
                end
            end
            RUN: begin
                if (bus.en) begin
                    q_d         = apply_mode(run_mode_q, q_q, bus.d, bus.sin_l, bus.sin_r);
                    remaining_d = remaining_q - CNT_W'(1);
                    done_d      = (remaining_q == CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

`ifdef SHREG_SNAPSHOT_EN
    logic [WIDTH-1:0] q_snap_q;
    logic             snap_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_snap_q     <= '0;
            snap_valid_q <= 1'b0;
        end else if (done_d) begin
            q_snap_q     <= q_d;
            snap_valid_q <= 1'b1;
        end else if (snap_clr) begin
            snap_valid_q <= 1'b0;
        end
    end

    assign bus.q_snap     = q_snap_q;
    assign bus.snap_valid = snap_valid_q;
`endif

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.q         = q_q;
    assign bus.sout_l    = q_q[WIDTH-1];
    assign bus.sout_r    = q_q[0];
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Scoreboard bench for univ_shift_reg_burst: per-edge expectations from an arithmetic
// reference model, popped and compared by a monitor after every rising edge.
module tb_univ_shift_reg_burst;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] RST_V = 8'hA5;
`ifdef SHREG_SNAPSHOT_EN
    localparam int EW = 2 * W + 5;
`else
    localparam int EW = W + 4;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    univ_shift_reg_burst_if #(.WIDTH(W)) bus ();
    univ_shift_reg_burst #(.WIDTH(W), .RESET_VAL(RST_V)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    // reference model state
    logic [W-1:0] m_q = RST_V;
    bit           m_busy = 0;
    bit           m_done = 0;
    int           m_left = 0;
    int           m_mode = 0;
    logic [W-1:0] m_snap = '0;
    bit           m_sv = 0;

    function automatic bit is_shift(input int mode);
        return mode == 1 || mode == 2 || mode == 4 || mode == 5 || mode == 6;
    endfunction

    function automatic logic [W-1:0] ref_op(input int mode, input logic [W-1:0] qv,
                                            input bit sl, input bit sr, input logic [W-1:0] dv);
        int v, r, msb;
        v = int'(qv);
        msb = 1 << (W - 1);
        case (mode)
            1:       r = (v * 2 + int'(sl)) % (1 << W);
            2:       r = v / 2 + (sr ? msb : 0);
            3:       r = int'(dv);
            4:       r = (v * 2) % (1 << W) + v / msb;
            5:       r = v / 2 + (v % 2) * msb;
            6:       r = v / 2 + (v & msb);
            7:       r = 0;
            default: r = v;
        endcase
        return W'(r);
    endfunction

    function automatic logic [EW-1:0] model_pack();
`ifdef SHREG_SNAPSHOT_EN
        return {m_sv, m_snap, m_busy, m_done, m_q[W-1], m_q[0], m_q};
`else
        return {m_busy, m_done, m_q[W-1], m_q[0], m_q};
`endif
    endfunction

    function automatic logic [EW-1:0] observed();
`ifdef SHREG_SNAPSHOT_EN
        return {bus.snap_valid, bus.q_snap, bus.busy, bus.done, bus.sout_l, bus.sout_r, bus.q};
`else
        return {bus.busy, bus.done, bus.sout_l, bus.sout_r, bus.q};
`endif
    endfunction

    task automatic model_reset();
        m_q = RST_V; m_busy = 0; m_done = 0; m_left = 0; m_mode = 0; m_snap = '0; m_sv = 0;
    endtask

    task automatic model_edge(input bit en, input int mode, input logic [W-1:0] dv,
                              input bit sl, input bit sr, input bit st, input int cnt);
        if (m_busy) begin
            if (en) begin
                m_q = ref_op(m_mode, m_q, sl, sr, '0);
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_snap = m_q; m_sv = 1;
                end
            end
        end else begin
            m_done = 0;
            if (en) begin
                if (st && is_shift(mode)) begin
                    if (cnt == 0) begin
                        m_done = 1; m_snap = m_q; m_sv = 1;
                    end else begin
                        m_busy = 1; m_mode = mode; m_left = cnt;
                    end
                end else begin
                    m_q = ref_op(mode, m_q, sl, sr, dv);
                    if (mode == 3 || mode == 7) m_sv = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    // driver tasks
    task automatic drive(input bit en, input int mode, input logic [W-1:0] dv,
                         input bit sl, input bit sr, input bit st, input int cnt);
        bus.en = en; bus.mode = 3'(mode); bus.d = dv; bus.sin_l = sl; bus.sin_r = sr;
        bus.start = st; bus.shift_cnt = CW'(cnt);
        model_edge(en, mode, dv, sl, sr, st, cnt);
        exp_q.push_back(model_pack());
    endtask

    task automatic cyc(input bit en, input int mode, input logic [W-1:0] dv,
                       input bit sl, input bit sr, input bit st, input int cnt);
        @(negedge clk);
        drive(en, mode, dv, sl, sr, st, cnt);
    endtask

    // burst body: ignored inputs randomised, serial inputs fixed
    task automatic run_cycles(input int n, input bit sl, input bit sr);
        for (int i = 0; i < n; i++)
            cyc(1, $urandom_range(0, 7), W'($urandom), sl, sr, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15));
    endtask

    task automatic rst_cyc();
        @(negedge clk);
        bus.en = 1'b1; bus.mode = 3'($urandom_range(0, 7)); bus.d = W'($urandom);
        bus.start = 1'b1; bus.shift_cnt = CW'($urandom_range(1, 15));
        model_reset();
        exp_q.push_back(model_pack());
    endtask

    task automatic release_reset(input logic [W-1:0] first_load);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        drive(1, 3, first_load, 0, 0, 0, 0);
    endtask

    // monitor
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("cycle", observed(), mon_e);
        end
    end

    initial begin
        bus.en = 0; bus.mode = 0; bus.d = 0; bus.sin_l = 0; bus.sin_r = 0;
        bus.start = 0; bus.shift_cnt = 0;

        // held reset while clocking with active inputs
        repeat (3) rst_cyc();
        release_reset(8'h96);

        // single ops from 1001_0110
        cyc(1, 1, 8'h00, 1, 0, 0, 0);
        cyc(1, 3, 8'h96, 0, 0, 0, 0);
        cyc(1, 5, 8'h00, 0, 0, 0, 0);
        cyc(1, 3, 8'h96, 0, 0, 0, 0);
        cyc(1, 6, 8'h00, 0, 0, 0, 0);
        cyc(1, 3, 8'h3C, 0, 0, 0, 0);
        cyc(1, 7, 8'hFF, 1, 1, 0, 0);

        // ROL burst of 3 on 81
        cyc(1, 3, 8'h81, 0, 0, 0, 0);
        cyc(1, 4, 8'h00, 0, 0, 1, 3);
        run_cycles(3, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);

        // SHR burst of 4 on F0 with a two-cycle stall
        cyc(1, 3, 8'hF0, 0, 0, 0, 0);
        cyc(1, 2, 8'h00, 0, 0, 1, 4);
        run_cycles(2, 0, 0);
        cyc(0, 3, 8'h55, 0, 0, 1, 2);
        cyc(0, 7, 8'hAA, 0, 0, 0, 5);
        run_cycles(2, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);

        // zero-length burst, then start with a non-shift mode
        cyc(1, 1, 8'h00, 1, 0, 1, 0);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 3, 8'h5A, 0, 0, 1, 3);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);

        // back-to-back bursts, second start in the done cycle
        cyc(1, 5, 8'h00, 0, 0, 1, 2);
        run_cycles(2, 1, 1);
        cyc(1, 4, 8'h00, 0, 0, 1, 2);
        run_cycles(2, 0, 1);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);

        // SHL burst of 2 on 01 (snapshot case), followed by a LOAD
        cyc(1, 3, 8'h01, 0, 0, 0, 0);
        cyc(1, 1, 8'h00, 0, 0, 1, 2);
        run_cycles(2, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 3, 8'h33, 0, 0, 0, 0);

        // asynchronous reset in the middle of a burst
        cyc(1, 4, 8'h00, 0, 0, 1, 6);
        run_cycles(2, 0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", observed(), model_pack());
        repeat (2) rst_cyc();
        release_reset(8'hC3);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 4) != 0), $urandom_range(0, 7), W'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), $urandom_range(0, 15));

        repeat (2) cyc(0, 0, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("drain", EW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg_burst.md
Name: univ_shift_reg_burst

Overview:
- Parametrised universal shift register and the successor to the single-bit async-reset D flip-flop in the shift-register library.
- Supports single-cycle operations: hold, logical shift, rotate, arithmetic shift, parallel load and clear.
- Adds a counted burst mode: one start request performs N consecutive shifts, with busy/done handshake.
- Used as the building block for serialisers, barrel-shift emulation and PISO/SIPO conversion in the sequential library.

Parameters:
WIDTH, 8, register width in bits (>=2)
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)
CNT_W, $clog2(WIDTH+1), width of shift_cnt; localparam, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  reset, asynchronous, active-low
en  in  1  clock enable; gates every operation, including start sampling and burst shifts
mode  in  3  operation select (encoding below)
d  in  WIDTH  parallel load data
sin_l  in  1  serial input into LSB on left shift
sin_r  in  1  serial input into MSB on logical right shift
start  in  1  burst request; sampled only in IDLE with en=1
shift_cnt  in  CNT_W  number of shifts for a burst
busy  out  1  high while a burst is in progress
done  out  1  single-cycle pulse after a burst completes
q  out  WIDTH  register contents
sout_l  out  1  q[WIDTH-1] (combinational from q)
sout_r  out  1  q[0] (combinational from q)

Behaviour:
- Mode encoding:
  - 000 HOLD
  - 001 SHL: q <= {q[W-2:0],sin_l}
  - 010 SHR: q <= {sin_r,q[W-1:1]}
  - 011 LOAD: q <= d
  - 100 ROL
  - 101 ROR
  - 110 ASR: MSB replicated
  - 111 CLR: q <= 0, not RESET_VAL
  - Shift-class modes: 001, 010, 100, 101, 110.
- Reset (async, any time, including mid-burst):
  - q=RESET_VAL, busy=0, done=0, FSM=IDLE.
  - Latched burst mode and counter cleared.
  - First operation is possible on the first rising edge after reset_n deasserts.
- FSM states: IDLE, RUN.
- IDLE, en=0: nothing changes; done cleared to 0.
- IDLE, en=1, start=0: apply mode for one cycle.
- IDLE, en=1, start=1, shift-class mode, shift_cnt>0:
  - q unchanged on that edge.
  - Latch mode into run_mode and shift_cnt into remaining.
  - Go to RUN; busy=1.
- IDLE, en=1, start=1, shift_cnt=0: q unchanged; done=1 next cycle; stay IDLE; busy stays 0.
- IDLE, en=1, start=1, non-shift mode: start ignored; mode applied as a single-cycle operation; no busy, no done.
- RUN, en=1:
  - Apply run_mode once; remaining decrements.
  - If remaining was 1: go to IDLE, busy<=0, done<=1 for exactly one cycle.
- RUN, en=0: stall; q, remaining and busy held.
- While busy: mode, d, start and shift_cnt are ignored.
- Latency: for a burst of N with en held high, the start edge is edge 0 and shifts occur on edges 1..N. After edge N, busy=0 and done=1. done clears after edge N+1.
- shift_cnt values above WIDTH execute literally (rotates wrap modulo WIDTH; logical shifts saturate to serial-fill content).
- done is registered. A new start is accepted on the same edge that clears done (back-to-back bursts allowed).

Optional Feature:
Macro SHREG_SNAPSHOT_EN.
- Defined:
  - Extra output q_snap [WIDTH] and snap_valid [1], both reset to 0.
  - On the edge that sets done, q_snap <= the post-burst q value and snap_valid <= 1.
  - snap_valid clears on the next LOAD or CLR operation.
- Undefined: ports absent; no extra flops.

Test Plan:
- Reset: hold reset_n=0 with RESET_VAL=8'hA5 while clocking -> q=A5, busy=0, done=0. Assert reset_n mid-burst -> q=A5 immediately, without waiting for a clock edge.
- Single ops from q=8'b1001_0110:
  - SHL sin_l=1 -> 0010_1101
  - ROR -> 0100_1011
  - ASR -> 1100_1011
  - LOAD d=3C -> 3C
  - CLR -> 00
- Burst: q=8'h81, mode=ROL, shift_cnt=3, start for 1 cycle -> busy high 3 cycles, q=8'h0C, done pulses once the cycle busy falls.
- Stall: burst SHR N=4 on q=F0, sin_r=0, en low for 2 cycles mid-burst -> q=0F, busy length 6 cycles, mode/d changes during the burst ignored.
- Edge cases:
  - start with shift_cnt=0 -> done pulse, q unchanged, busy never high.
  - start with mode=LOAD -> q=d, no done.
  - Back-to-back bursts (start asserted in the done cycle) -> second burst accepted.
- With SHREG_SNAPSHOT_EN: burst SHL N=2 on 8'h01 with sin_l=0 -> q_snap=04, snap_valid=1. Subsequent LOAD -> snap_valid=0.
